// File: rtl/debounce_sync.sv
// debounce_sync: two-flop synchroniser followed by a stability filter.
// q follows the synchronised input only after it has differed from q for
// STABLE_CYCLES consecutive edges; rise/fall pulse for one cycle on each
// accepted change. All outputs are registered; qn is the complement of q.
module debounce_sync #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk,
  input  logic clr_n,
  input  logic din,
  output logic q,
  output logic qn,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  logic             s1;
  logic             s2;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             q_r;
  logic             q_nxt;
  logic             rise_r;
  logic             rise_nxt;
  logic             fall_r;
  logic             fall_nxt;

  // Two-flop synchroniser bringing din into the clk domain.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // State register: FSM state, stability counter and the registered outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= ST_STABLE;
      cnt    <= '0;
      q_r    <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      q_r    <= q_nxt;
      rise_r <= rise_nxt;
      fall_r <= fall_nxt;
    end
  end

  // Next-state logic: count consecutive disagreements, commit on the last one.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    q_nxt     = q_r;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    unique case (state)
      ST_STABLE: begin
        if (s2 != q_r) begin
          if (STABLE_CYCLES == 1) begin
            q_nxt    = s2;
            rise_nxt = s2;
            fall_nxt = ~s2;
          end else begin
            state_nxt = ST_PENDING;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      ST_PENDING: begin
        if (s2 == q_r) begin
          state_nxt = ST_STABLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_STABLE;
          q_nxt     = s2;
          rise_nxt  = s2;
          fall_nxt  = ~s2;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_STABLE;
      end
    endcase
  end

  // Output logic: expose the registered level, its complement and the pulses.
  always_comb begin
    q    = q_r;
    qn   = ~q_r;
    rise = rise_r;
    fall = fall_r;
  end

endmodule
